// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops and bit-serial shifts that
// take one cycle per shift position, with a valid/ready request and result port.
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_control,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy
);

    // Operation codes, {funct7[5], funct3} as produced by the decoder.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] acc, acc_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [3:0]  op_q, op_nx;
    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic        is_shift;
    logic        accept;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. Requests transfer only in IDLE without flush; the result
    // transfers only in DONE, and DONE is left on that same edge.
    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;
    assign zero      = (acc == 32'd0);

    assign shamt    = operand_b[4:0];
    assign is_shift = (alu_control == ALU_SLL) || (alu_control == ALU_SRL) ||
                      (alu_control == ALU_SRA);

    // Single-cycle results; shift codes fall to the default and are never used here.
    always_comb begin
        alu_res = operand_a + operand_b;
        case (alu_control)
            ALU_SUB:  alu_res = operand_a - operand_b;
            ALU_SLT:  alu_res = {31'd0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_res = {31'd0, operand_a < operand_b};
            ALU_XOR:  alu_res = operand_a ^ operand_b;
            ALU_OR:   alu_res = operand_a | operand_b;
            ALU_AND:  alu_res = operand_a & operand_b;
            default:  alu_res = operand_a + operand_b;
        endcase
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        op_nx    = op_q;
        if (flush) begin
            state_nx = IDLE;
            acc_nx   = 32'd0;
            cnt_nx   = 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_nx = alu_control;
                        if (is_shift && (shamt != 5'd0)) begin
                            state_nx = SHIFT;
                            acc_nx   = operand_a;
                            cnt_nx   = shamt;
                        end else begin
                            state_nx = DONE;
                            acc_nx   = is_shift ? operand_a : alu_res;
                            cnt_nx   = 5'd0;
                        end
                    end
                end
                SHIFT: begin
                    case (op_q)
                        ALU_SLL: acc_nx = {acc[30:0], 1'b0};
                        ALU_SRL: acc_nx = {1'b0, acc[31:1]};
                        default: acc_nx = {acc[31], acc[31:1]};
                    endcase
                    cnt_nx = cnt - 5'd1;
                    // Last step happens on this edge, so DONE follows directly.
                    if (cnt == 5'd1) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 32'd0;
            cnt   <= 5'd0;
            op_q  <= ALU_ADD;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: in_valid  input  1  request present on alu_control/operand_a/operand_b.
REQ-004 SHALL: in_ready  output  1  unit can accept a request this cycle.
REQ-005 SHALL: alu_control  input  4  operation code, using the ALU_* encodings defined in isa.v (the same code that alu_control produces).
REQ-006 SHALL: operand_a  input  32  first operand; shift source for SLL/SRL/SRA.
REQ-007 SHALL: operand_b  input  32  second operand; bits [4:0] are the shift amount for shifts.
REQ-008 SHALL: flush  input  1  synchronous abort of any in-flight operation.
REQ-009 SHALL: out_valid  output  1  result and zero are valid.
REQ-010 SHALL: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 SHALL: result  output  32  operation result.
REQ-012 SHALL: zero  output  1  result == 0.
REQ-013 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL: FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE) and not flush.
REQ-015 SHALL: accept a request when in_valid and in_ready are both high at a rising edge, latching alu_control, operand_a and operand_b[4:0].
REQ-016 SHALL: non-shift operations transition IDLE -> DONE with result registered; out_valid is high in the cycle after acceptance (latency 1).
REQ-017 SHALL: ADD/SUB wrap modulo 2^32; no overflow or carry output.
REQ-018 SHALL: SLT compares signed and SLTU compares unsigned; result is 32'd1 if a < b, else 32'd0.
REQ-019 SHALL: XOR, OR and AND are bitwise over 32 bits.
REQ-020 SHALL: any unlisted alu_control code executes as ADD.
REQ-021 SHALL: shift operations with shamt == 0 go IDLE -> DONE with result = operand_a (latency 1).
REQ-022 SHALL: shift operations with shamt > 0 go IDLE -> SHIFT, load the working register with operand_a, then shift it one bit per cycle while decrementing a 5-bit counter, and enter DONE when the counter reaches 0; out_valid first rises shamt+1 cycles after acceptance.
REQ-023 SHALL: SLL fills with 0 from the LSB, SRL fills with 0 from the MSB, and SRA replicates bit 31 at each step.
REQ-024 SHALL: in DONE, out_valid is held high with result and zero stable until out_ready is high at a clock edge; the FSM then returns to IDLE and out_valid falls the next cycle.
REQ-025 SHALL: out_ready is ignored while out_valid is low.
REQ-026 SHALL: no new request is accepted in the same cycle that DONE is exited; the maximum throughput is one result per 2 cycles.
REQ-027 SHALL: flush high at a clock edge forces the FSM to IDLE, clears out_valid and discards any result; flush takes priority over out_ready and in_valid.
REQ-028 SHALL: input changes while the FSM is not in IDLE have no effect on the in-flight operation.

Reset
REQ-029 SHALL: while rst is high, state = IDLE, out_valid = 0, result = 0, zero = 1, busy = 0, and the shift counter = 0, applied immediately without waiting for clk.
REQ-030 SHALL: rst asserted mid-operation aborts that operation and produces no out_valid pulse after release.
REQ-031 SHALL: in_ready is high in the first cycle after rst deasserts.

Verification
REQ-032 SHALL: ADD with a = 0xFFFFFFFF and b = 1, out_ready = 1 -> out_valid one cycle after acceptance, result = 0, zero = 1.
REQ-033 SHALL: SLT with a = 0xFFFFFFFF and b = 1 -> result = 1; SLTU with the same operands -> result = 0.
REQ-034 SHALL: SRA with a = 0x80000000 and b = 31 -> out_valid 32 cycles after acceptance, result = 0xFFFFFFFF, and busy high for 31 cycles before DONE.
REQ-035 SHALL: SLL with a = 1 and b = 0x24 (shamt 4) and out_ready held low for 5 cycles -> result = 0x10 held stable with out_valid high, then the FSM returns to IDLE one cycle after out_ready rises.
REQ-036 SHALL: flush asserted 3 cycles into SRL with shamt 10 -> FSM returns to IDLE the next cycle, out_valid never rises, and a following XOR with a = 0xF0 and b = 0xFF gives result = 0x0F.
REQ-037 SHALL: rst asserted asynchronously during SHIFT -> out_valid = 0 and busy = 0 immediately, and in_ready = 1 the cycle after release.
